// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto a single physical memory port.
// Latency: pmem request issued 1 cycle after the grant decision; resp pulses 1 cycle after pmem_resp.
// Backpressure: requests are level-held; the arbiter waits on pmem_resp indefinitely, one transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset_n,

    // instruction-cache fill port
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    // data-cache fill / writeback port
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    // shared physical memory port
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BUSY  = 2'd1,
        D_BUSY  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------
    state_t              r_state;
    logic                r_last_d;      // 1: last grant went to D, 0: to I
    logic                r_op_wr;       // in-flight transaction is a write
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_address;
    logic [LINE_W-1:0]   r_pmem_wdata;
    logic [LINE_W-1:0]   r_i_rdata;
    logic [LINE_W-1:0]   r_d_rdata;
    logic                r_i_resp;
    logic                r_d_resp;

    // ---------------------------------------------------------------
    // Next-state values
    // ---------------------------------------------------------------
    state_t              w_state;
    logic                w_last_d;
    logic                w_op_wr;
    logic                w_pmem_read;
    logic                w_pmem_write;
    logic [ADDR_W-1:0]   w_pmem_address;
    logic [LINE_W-1:0]   w_pmem_wdata;
    logic [LINE_W-1:0]   w_i_rdata;
    logic [LINE_W-1:0]   w_d_rdata;
    logic                w_i_resp;
    logic                w_d_resp;

    logic                w_i_req;
    logic                w_d_req;
    logic                w_d_is_wr;
    logic                w_pick_d;

    // A D-side request with both strobes high is a writeback; d_read is ignored then.
    assign w_i_req   = i_read;
    assign w_d_req   = d_read | d_write;
    assign w_d_is_wr = d_write;

    // On a tie, the side that did not win last time gets the port.
    assign w_pick_d  = w_d_req & (~w_i_req | ~r_last_d);

    // State register and all output registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_last_d       <= 1'b0;
            r_op_wr        <= 1'b0;
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_last_d       <= w_last_d;
            r_op_wr        <= w_op_wr;
            r_pmem_read    <= w_pmem_read;
            r_pmem_write   <= w_pmem_write;
            r_pmem_address <= w_pmem_address;
            r_pmem_wdata   <= w_pmem_wdata;
            r_i_rdata      <= w_i_rdata;
            r_d_rdata      <= w_d_rdata;
            r_i_resp       <= w_i_resp;
            r_d_resp       <= w_d_resp;
        end
    end

    // Grant decision, pmem handshake tracking and response generation.
    always_comb begin
        // hold everything by default; resp strobes are single-cycle pulses
        w_state        = r_state;
        w_last_d       = r_last_d;
        w_op_wr        = r_op_wr;
        w_pmem_read    = r_pmem_read;
        w_pmem_write   = r_pmem_write;
        w_pmem_address = r_pmem_address;
        w_pmem_wdata   = r_pmem_wdata;
        w_i_rdata      = r_i_rdata;
        w_d_rdata      = r_d_rdata;
        w_i_resp       = 1'b0;
        w_d_resp       = 1'b0;

        case (r_state)
            IDLE: begin
                // pmem_resp is deliberately not looked at here
                if (w_pick_d) begin
                    w_state        = D_BUSY;
                    w_last_d       = 1'b1;
                    w_op_wr        = w_d_is_wr;
                    w_pmem_address = d_address;
                    w_pmem_wdata   = d_wdata;
                    w_pmem_write   = w_d_is_wr;
                    w_pmem_read    = ~w_d_is_wr;
                end else if (w_i_req) begin
                    // the I side has no write data; pmem_wdata keeps its last value
                    w_state        = I_BUSY;
                    w_last_d       = 1'b0;
                    w_op_wr        = 1'b0;
                    w_pmem_address = i_address;
                    w_pmem_write   = 1'b0;
                    w_pmem_read    = 1'b1;
                end else begin
                    w_pmem_read    = 1'b0;
                    w_pmem_write   = 1'b0;
                end
            end

            I_BUSY, D_BUSY: begin
                // request strobes are not re-examined: a dropped request still completes
                w_pmem_read  = ~r_op_wr;
                w_pmem_write = r_op_wr;
                if (pmem_resp) begin
                    w_state      = RESPOND;
                    w_pmem_read  = 1'b0;
                    w_pmem_write = 1'b0;
                    if (r_state == I_BUSY) begin
                        w_i_rdata = pmem_rdata;
                        w_i_resp  = 1'b1;
                    end else begin
                        if (!r_op_wr) begin
                            w_d_rdata = pmem_rdata;
                        end
                        w_d_resp = 1'b1;
                    end
                end
            end

            RESPOND: begin
                // resp is high during this state; no new grant until back in IDLE
                w_state      = IDLE;
                w_pmem_read  = 1'b0;
                w_pmem_write = 1'b0;
            end

            default: begin
                w_state      = IDLE;
                w_pmem_read  = 1'b0;
                w_pmem_write = 1'b0;
            end
        endcase
    end

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign i_rdata      = r_i_rdata;
    assign i_resp       = r_i_resp;
    assign d_rdata      = r_d_rdata;
    assign d_resp       = r_d_resp;

endmodule
